// File: rtl/ss_pkg.sv
// ---------------------------------------------------------------------------
// ss_pkg
// Shared types and helpers for the multi-channel start arbiter.
//   state_t   : arbiter FSM state (S_IDLE, S_BUSY)
//   idx_width : width of a channel index, never less than one bit
// ---------------------------------------------------------------------------
package ss_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   // A single channel would give $clog2 = 0; keep at least one index bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ss_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ss_rr_arbiter
// Combinational round-robin priority select. The winner is the first set
// request bit found searching upward from ptr, wrapping modulo NUM_CH.
// Ports:
//   req       in  NUM_CH  request vector
//   ptr       in  IDX_W   highest-priority channel for this search
//   gnt_valid out 1       at least one request is set
//   gnt_idx   out IDX_W   index of the winning channel (0 when none)
// ---------------------------------------------------------------------------
module ss_rr_arbiter
   import ss_pkg::*;
#(
   parameter  int NUM_CH = 4,
   localparam int IDX_W  = idx_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic              gnt_valid,
   output logic [IDX_W-1:0]  gnt_idx
);

   localparam logic [IDX_W:0] NUM_CH_W = (IDX_W + 1)'(NUM_CH);

   // cand_idx[gi] is the channel examined at search position gi.
   logic [IDX_W-1:0]  cand_idx [NUM_CH];
   logic [NUM_CH-1:0] cand_req;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         // ptr < NUM_CH and gi < NUM_CH, so one conditional subtract wraps.
         assign sum          = {1'b0, ptr} + (IDX_W + 1)'(gi);
         assign cand_idx[gi] = (sum >= NUM_CH_W) ? IDX_W'(sum - NUM_CH_W)
                                                 : sum[IDX_W-1:0];
         assign cand_req[gi] = req[cand_idx[gi]];
      end
   endgenerate

   // Scan from the far end so the lowest search position wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (cand_req[i]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx[i];
         end
      end
   end

endmodule

// File: rtl/ss_start_arbiter.sv
// ---------------------------------------------------------------------------
// ss_start_arbiter
// Latches per-channel start requests and hands them, one at a time and in
// round-robin order, to a shared engine. The engine is held busy until it
// reports done or the watchdog expires.
// Ports:
//   i_clk       in  1       clock
//   i_rst_n     in  1       asynchronous active-low reset
//   i_clr       in  1       synchronous soft clear (pointer and grant id kept)
//   i_start     in  NUM_CH  per-channel start (pulse or level)
//   i_done      in  1       engine completion pulse
//   o_eng_start out 1       one-cycle start pulse to the engine
//   o_grant_id  out IDX_W   channel currently / last served
//   o_busy      out 1       engine owned by a channel
//   o_pending   out NUM_CH  latched, unserved requests
//   o_done_ch   out NUM_CH  one-hot completion pulse to the served channel
//   o_timeout   out 1       one-cycle pulse on watchdog abort
//   o_overrun   out NUM_CH  sticky: start while already pending/active
// ---------------------------------------------------------------------------
module ss_start_arbiter
   import ss_pkg::*;
#(
   parameter  int NUM_CH    = 4,
   parameter  int TIMEOUT_W = 16,
   parameter  int TIMEOUT   = 1000,
   localparam int IDX_W     = idx_width(NUM_CH)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic [NUM_CH-1:0] i_start,
   input  logic              i_done,
   output logic              o_eng_start,
   output logic [IDX_W-1:0]  o_grant_id,
   output logic              o_busy,
   output logic [NUM_CH-1:0] o_pending,
   output logic [NUM_CH-1:0] o_done_ch,
   output logic              o_timeout,
   output logic [NUM_CH-1:0] o_overrun
);

   generate
      if (NUM_CH < 2) begin : g_bad_num_ch
         $error("ss_start_arbiter: NUM_CH must be at least 2");
      end
      if (TIMEOUT < 0 || longint'(TIMEOUT) >= (longint'(1) << TIMEOUT_W)) begin : g_bad_timeout
         $error("ss_start_arbiter: TIMEOUT must fit in TIMEOUT_W bits");
      end
   endgenerate

   localparam bit                 WD_EN   = (TIMEOUT != 0);
   localparam logic [TIMEOUT_W-1:0] WD_LAST = (TIMEOUT > 0) ? TIMEOUT_W'(TIMEOUT - 1) : '0;
   localparam logic [IDX_W-1:0]   LAST_CH = IDX_W'(NUM_CH - 1);

   state_t               state_reg;
   logic [IDX_W-1:0]     ptr_reg;
   logic [TIMEOUT_W-1:0] wd_reg;
   logic [NUM_CH-1:0]    pending_reg;
   logic [NUM_CH-1:0]    overrun_reg;
   logic [IDX_W-1:0]     grant_id_reg;
   logic                 eng_start_reg;
   logic                 busy_reg;
   logic [NUM_CH-1:0]    done_ch_reg;
   logic                 timeout_reg;

   logic [NUM_CH-1:0]    active_mask;
   logic [NUM_CH-1:0]    win_mask;
   logic [NUM_CH-1:0]    blocked_mask;
   logic [NUM_CH-1:0]    new_req;
   logic [NUM_CH-1:0]    overrun_hit;
   logic [NUM_CH-1:0]    pending_next;
   logic [IDX_W-1:0]     ptr_next;
   logic                 wd_expire;
   logic                 arb_valid;
   logic [IDX_W-1:0]     arb_idx;

   ss_rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_rr (
      .req       (pending_reg),
      .ptr       (ptr_reg),
      .gnt_valid (arb_valid),
      .gnt_idx   (arb_idx)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_masks
         assign active_mask[gi] = busy_reg && (grant_id_reg == IDX_W'(gi));
         assign win_mask[gi]    = (state_reg == S_IDLE) && arb_valid && (arb_idx == IDX_W'(gi));
      end
   endgenerate

   // The active channel may re-request in its own done cycle; otherwise a
   // start on a pending or active channel is an overrun and is dropped.
   assign blocked_mask = pending_reg | (active_mask & ~{NUM_CH{i_done}});
   assign new_req      = i_start & ~blocked_mask;
   assign overrun_hit  = i_start & blocked_mask;
   assign pending_next = (pending_reg | new_req) & ~win_mask;
   assign ptr_next     = (grant_id_reg == LAST_CH) ? '0 : grant_id_reg + IDX_W'(1);
   assign wd_expire    = WD_EN && (wd_reg == WD_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg     <= S_IDLE;
         ptr_reg       <= '0;
         wd_reg        <= '0;
         pending_reg   <= '0;
         overrun_reg   <= '0;
         grant_id_reg  <= '0;
         eng_start_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_ch_reg   <= '0;
         timeout_reg   <= 1'b0;
      end else if (i_clr) begin
         // Pointer and last grant id survive a soft clear.
         state_reg     <= S_IDLE;
         wd_reg        <= '0;
         pending_reg   <= '0;
         overrun_reg   <= '0;
         eng_start_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_ch_reg   <= '0;
         timeout_reg   <= 1'b0;
      end else begin
         eng_start_reg <= 1'b0;
         done_ch_reg   <= '0;
         timeout_reg   <= 1'b0;
         pending_reg   <= pending_next;
         overrun_reg   <= overrun_reg | overrun_hit;
         case (state_reg)
            S_IDLE: begin
               if (arb_valid) begin
                  state_reg     <= S_BUSY;
                  eng_start_reg <= 1'b1;
                  busy_reg      <= 1'b1;
                  grant_id_reg  <= arb_idx;
                  wd_reg        <= '0;
               end
            end
            S_BUSY: begin
               // Done takes precedence over a simultaneous watchdog expiry.
               if (i_done) begin
                  state_reg   <= S_IDLE;
                  busy_reg    <= 1'b0;
                  done_ch_reg <= active_mask;
                  ptr_reg     <= ptr_next;
                  wd_reg      <= '0;
               end else if (wd_expire) begin
                  state_reg   <= S_IDLE;
                  busy_reg    <= 1'b0;
                  timeout_reg <= 1'b1;
                  ptr_reg     <= ptr_next;
                  wd_reg      <= '0;
               end else if (WD_EN && (wd_reg != '1)) begin
                  wd_reg <= wd_reg + TIMEOUT_W'(1);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign o_eng_start = eng_start_reg;
   assign o_grant_id  = grant_id_reg;
   assign o_busy      = busy_reg;
   assign o_pending   = pending_reg;
   assign o_done_ch   = done_ch_reg;
   assign o_timeout   = timeout_reg;
   assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_ss_start_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ss_start_arbiter
// Directed bench for ss_start_arbiter. Two instances share the stimulus:
// dut (default watchdog) and wdut (TIMEOUT=8, TIMEOUT_W=4). Every scenario
// starts from reset, so the instance not under test is irrelevant.
// ---------------------------------------------------------------------------
module tb_ss_start_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       done;
   logic [3:0] start;

   logic       eng_start, busy, timeout;
   logic [1:0] grant_id;
   logic [3:0] pending, done_ch, overrun;

   logic       w_eng_start, w_busy, w_timeout;
   logic [1:0] w_grant_id;
   logic [3:0] w_pending, w_done_ch, w_overrun;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   ss_start_arbiter #(.NUM_CH(4), .TIMEOUT_W(16), .TIMEOUT(1000)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_start(start), .i_done(done),
      .o_eng_start(eng_start), .o_grant_id(grant_id), .o_busy(busy),
      .o_pending(pending), .o_done_ch(done_ch), .o_timeout(timeout),
      .o_overrun(overrun)
   );

   ss_start_arbiter #(.NUM_CH(4), .TIMEOUT_W(4), .TIMEOUT(8)) wdut (
      .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_start(start), .i_done(done),
      .o_eng_start(w_eng_start), .o_grant_id(w_grant_id), .o_busy(w_busy),
      .o_pending(w_pending), .o_done_ch(w_done_ch), .o_timeout(w_timeout),
      .o_overrun(w_overrun)
   );

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      start = '0; done = 1'b0; clr = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if ({eng_start, busy, timeout, grant_id, pending, done_ch, overrun} !== 17'd0)
         $display("FAIL reset_main: got %h want 0", {eng_start, busy, timeout, grant_id, pending, done_ch, overrun}); else n_pass++;
      n_checks++; if ({w_eng_start, w_busy, w_timeout, w_grant_id, w_pending, w_done_ch, w_overrun} !== 17'd0)
         $display("FAIL reset_wd: got %h want 0", {w_eng_start, w_busy, w_timeout, w_grant_id, w_pending, w_done_ch, w_overrun}); else n_pass++;
      repeat (3) tick();
      n_checks++; if ({eng_start, busy} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {eng_start, busy}); else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_single();
      do_reset();
      start = 4'b0100;                 // cycle t
      tick(); start = '0;              // t+1
      n_checks++; if (pending !== 4'b0100) $display("FAIL single_pending: got %b want 0100", pending); else n_pass++;
      n_checks++; if (eng_start !== 1'b0) $display("FAIL single_early_start: got %b want 0", eng_start); else n_pass++;
      tick();                          // t+2
      n_checks++; if (eng_start !== 1'b1) $display("FAIL single_eng_start: got %b want 1", eng_start); else n_pass++;
      n_checks++; if (grant_id !== 2'd2) $display("FAIL single_grant: got %0d want 2", grant_id); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
      n_checks++; if (pending !== 4'b0000) $display("FAIL single_pending_clr: got %b want 0000", pending); else n_pass++;
      tick();                          // t+3
      n_checks++; if (eng_start !== 1'b0) $display("FAIL single_start_pulse: got %b want 0", eng_start); else n_pass++;
      repeat (7) tick();               // t+10
      n_checks++; if (busy !== 1'b1) $display("FAIL single_still_busy: got %b want 1", busy); else n_pass++;
      done = 1'b1;
      tick(); done = 1'b0;             // t+11
      n_checks++; if (done_ch !== 4'b0100) $display("FAIL single_done_ch: got %b want 0100", done_ch); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_drop: got %b want 0", busy); else n_pass++;
      tick();                          // t+12
      n_checks++; if (done_ch !== 4'b0000) $display("FAIL single_done_pulse: got %b want 0000", done_ch); else n_pass++;
      n_checks++; if (grant_id !== 2'd2) $display("FAIL single_grant_hold: got %0d want 2", grant_id); else n_pass++;
      $display("test_single done");
   endtask

   task automatic test_round_robin();
      int         exp_order [6] = '{0, 1, 2, 3, 0, 3};
      logic [3:0] exp_oh;
      int         w;
      do_reset();
      start = 4'b1111;
      tick(); start = '0;
      n_checks++; if (pending !== 4'b1111) $display("FAIL rr_pending: got %b want 1111", pending); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         // One idle cycle before each grant: pending-set or done-cycle + 1.
         w = 0;
         while (eng_start !== 1'b1 && w < 20) begin
            tick();
            w++;
         end
         n_checks++; if (w !== 1) $display("FAIL rr_gap%0d: got %0d cycles want 1", i, w); else n_pass++;
         n_checks++; if (grant_id !== 2'(exp_order[i])) $display("FAIL rr_grant%0d: got %0d want %0d", i, grant_id, exp_order[i]); else n_pass++;
         repeat (4) tick();            // fifth busy cycle
         done = 1'b1;
         if (i == 3) start = 4'b1001;  // ch3 re-requests in its own done cycle
         tick();
         done = 1'b0; start = '0;
         exp_oh = 4'b0001 << exp_order[i];
         n_checks++; if (done_ch !== exp_oh) $display("FAIL rr_done_ch%0d: got %b want %b", i, done_ch, exp_oh); else n_pass++;
         n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle%0d: got %b want 0", i, busy); else n_pass++;
      end
      n_checks++; if (pending !== 4'b0000) $display("FAIL rr_pending_end: got %b want 0000", pending); else n_pass++;
      n_checks++; if (overrun !== 4'b0000) $display("FAIL rr_overrun: got %b want 0000", overrun); else n_pass++;
      $display("test_round_robin done");
   endtask

   task automatic test_overrun();
      int extra;
      do_reset();
      start = 4'b0010;                 // t
      tick();                          // t+1, ch1 pending: second start overruns
      n_checks++; if (pending !== 4'b0010) $display("FAIL ovr_pending: got %b want 0010", pending); else n_pass++;
      tick(); start = '0;              // t+2
      n_checks++; if (overrun !== 4'b0010) $display("FAIL ovr_flag: got %b want 0010", overrun); else n_pass++;
      n_checks++; if (eng_start !== 1'b1 || grant_id !== 2'd1) $display("FAIL ovr_grant: got start=%b id=%0d want 1/1", eng_start, grant_id); else n_pass++;
      tick(); done = 1'b1;             // t+3
      tick(); done = 1'b0;             // t+4
      n_checks++; if (done_ch !== 4'b0010) $display("FAIL ovr_done_ch: got %b want 0010", done_ch); else n_pass++;
      n_checks++; if (pending !== 4'b0000) $display("FAIL ovr_pending_clr: got %b want 0000", pending); else n_pass++;
      extra = 0;
      repeat (4) begin
         tick();
         if (eng_start === 1'b1) extra++;
      end
      n_checks++; if (extra !== 0) $display("FAIL ovr_single_serve: got %0d extra grants want 0", extra); else n_pass++;
      n_checks++; if (overrun !== 4'b0010) $display("FAIL ovr_sticky: got %b want 0010", overrun); else n_pass++;
      clr = 1'b1; start = 4'b0001;     // start coincident with clear is dropped
      tick(); clr = 1'b0; start = '0;
      n_checks++; if (overrun !== 4'b0000) $display("FAIL ovr_clr: got %b want 0000", overrun); else n_pass++;
      n_checks++; if (pending !== 4'b0000) $display("FAIL clr_start_drop: got %b want 0000", pending); else n_pass++;
      tick();
      n_checks++; if ({eng_start, busy} !== 2'b00) $display("FAIL clr_no_grant: got %b want 00", {eng_start, busy}); else n_pass++;
      $display("test_overrun done");
   endtask

   task automatic test_clear_busy();
      do_reset();
      start = 4'b0100;
      tick(); start = '0;
      tick();
      tick();
      n_checks++; if (busy !== 1'b1) $display("FAIL clrb_busy: got %b want 1", busy); else n_pass++;
      clr = 1'b1;
      tick(); clr = 1'b0;
      n_checks++; if (busy !== 1'b0) $display("FAIL clrb_idle: got %b want 0", busy); else n_pass++;
      n_checks++; if ({done_ch, timeout} !== 5'd0) $display("FAIL clrb_no_pulse: got %b want 00000", {done_ch, timeout}); else n_pass++;
      n_checks++; if (grant_id !== 2'd2) $display("FAIL clrb_grant_hold: got %0d want 2", grant_id); else n_pass++;
      $display("test_clear_busy done");
   endtask

   task automatic test_watchdog();
      do_reset();
      start = 4'b0001;
      tick(); start = '0;
      tick();                          // E
      n_checks++; if (w_eng_start !== 1'b1 || w_grant_id !== 2'd0) $display("FAIL wd_grant0: got start=%b id=%0d want 1/0", w_eng_start, w_grant_id); else n_pass++;
      start = 4'b0010;
      tick(); start = '0;              // E+1
      repeat (6) tick();               // E+7
      n_checks++; if (w_timeout !== 1'b0 || w_busy !== 1'b1) $display("FAIL wd_early: got to=%b busy=%b want 0/1", w_timeout, w_busy); else n_pass++;
      n_checks++; if (w_pending !== 4'b0010) $display("FAIL wd_pending: got %b want 0010", w_pending); else n_pass++;
      tick();                          // E+8
      n_checks++; if (w_timeout !== 1'b1) $display("FAIL wd_timeout: got %b want 1", w_timeout); else n_pass++;
      n_checks++; if (w_done_ch !== 4'b0000 || w_busy !== 1'b0) $display("FAIL wd_abort: got done_ch=%b busy=%b want 0000/0", w_done_ch, w_busy); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL wd_long_timeout: got %b want 1", busy); else n_pass++;
      tick();                          // E+9
      n_checks++; if (w_eng_start !== 1'b1 || w_grant_id !== 2'd1) $display("FAIL wd_next_grant: got start=%b id=%0d want 1/1", w_eng_start, w_grant_id); else n_pass++;
      n_checks++; if (w_timeout !== 1'b0) $display("FAIL wd_pulse: got %b want 0", w_timeout); else n_pass++;
      $display("test_watchdog done");
   endtask

   task automatic test_collision();
      do_reset();
      start = 4'b0001;
      tick(); start = '0;
      tick();                          // E
      repeat (7) tick();               // E+7, expiry cycle
      done = 1'b1;
      tick(); done = 1'b0;             // E+8
      n_checks++; if (w_done_ch !== 4'b0001) $display("FAIL col_done_ch: got %b want 0001", w_done_ch); else n_pass++;
      n_checks++; if (w_timeout !== 1'b0) $display("FAIL col_timeout: got %b want 0", w_timeout); else n_pass++;
      n_checks++; if (w_busy !== 1'b0) $display("FAIL col_busy: got %b want 0", w_busy); else n_pass++;
      tick(); tick();
      done = 1'b1;                     // stray done while idle
      tick(); done = 1'b0;
      n_checks++; if ({w_eng_start, w_busy, w_timeout, w_grant_id, w_pending, w_done_ch, w_overrun} !== 17'd0)
         $display("FAIL stray_done: got %h want 0", {w_eng_start, w_busy, w_timeout, w_grant_id, w_pending, w_done_ch, w_overrun}); else n_pass++;
      tick();
      n_checks++; if ({w_eng_start, w_busy} !== 2'b00) $display("FAIL stray_done_late: got %b want 00", {w_eng_start, w_busy}); else n_pass++;
      $display("test_collision done");
   endtask

   task automatic test_async_reset();
      do_reset();
      start = 4'b0001;
      tick(); start = 4'b1010;
      tick(); start = '0;
      tick();
      n_checks++; if (busy !== 1'b1 || pending !== 4'b1010) $display("FAIL ar_setup: got busy=%b pend=%b want 1/1010", busy, pending); else n_pass++;
      #3 rst_n = 1'b0;
      #1;
      n_checks++; if ({eng_start, busy, timeout, grant_id, pending, done_ch, overrun} !== 17'd0)
         $display("FAIL ar_immediate: got %h want 0", {eng_start, busy, timeout, grant_id, pending, done_ch, overrun}); else n_pass++;
      tick();
      rst_n = 1'b1;
      tick();
      start = 4'b1000;
      tick(); start = '0;
      n_checks++; if (pending !== 4'b1000) $display("FAIL ar_pending: got %b want 1000", pending); else n_pass++;
      tick();
      n_checks++; if (eng_start !== 1'b1 || grant_id !== 2'd3) $display("FAIL ar_grant: got start=%b id=%0d want 1/3", eng_start, grant_id); else n_pass++;
      $display("test_async_reset done");
   endtask

   initial begin
      rst_n = 1'b0; start = '0; done = 1'b0; clr = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_overrun();
      test_clear_busy();
      test_watchdog();
      test_collision();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/ss_start_arbiter.md
Name: ss_start_arbiter

Overview:
- Multi-channel successor to the single-channel start latch.
- Each of NUM_CH requesters issues a start pulse. The block latches it as pending until served.
- A round-robin arbiter hands one request at a time to a shared engine and holds it busy until the engine reports done or a watchdog expires.
- Sits between per-channel control logic and the shared compute engine.

Parameters:
- NUM_CH, 4, number of requesting channels (≥2).
- TIMEOUT_W, 16, width of the watchdog counter.
- TIMEOUT, 1000, busy cycles before abort; 0 disables the watchdog.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: asynchronous, active-low.
- i_clr  in  1  synchronous soft clear.
- i_start  in  NUM_CH  per-channel start pulse (level also accepted, edge not required).
- i_done  in  1  engine completion pulse.
- o_eng_start  out  1  one-cycle start pulse to the engine.
- o_grant_id  out  $clog2(NUM_CH)  channel currently/last served.
- o_busy  out  1  engine owned by a channel.
- o_pending  out  NUM_CH  latched, unserved requests.
- o_done_ch  out  NUM_CH  one-hot one-cycle completion pulse to the served channel.
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_overrun  out  NUM_CH  sticky: start seen while that channel was already pending or active.

Behaviour:
- Reset: all outputs 0, FSM S_IDLE, round-robin pointer 0 (channel 0 highest priority first), watchdog 0.
- Pending set: i_start[k]=1 at cycle t with channel k neither pending nor active sets o_pending[k] at t+1.
- Overrun: i_start[k] while pending[k]=1, or while k is active and i_done=0, sets o_overrun[k]. The request is dropped.
- Same-cycle start and done: i_start[k] in the same cycle as i_done for active channel k is a new valid request.
- FSM S_IDLE:
  - If o_pending≠0, the winner is the first set bit searching upward from the pointer, wrapping modulo NUM_CH.
  - Next cycle: S_BUSY, o_eng_start=1 for exactly that cycle, o_busy=1, o_grant_id=winner, o_pending[winner] cleared, watchdog=0.
  - Latency: start to o_eng_start is 2 cycles when idle.
- FSM S_BUSY:
  - On i_done: next cycle S_IDLE, o_busy=0, o_done_ch[grant_id]=1 for one cycle, pointer=grant_id+1 (wraps).
  - Otherwise, with TIMEOUT≠0, the watchdog increments each cycle.
  - Watchdog reaching TIMEOUT-1 with no done: next cycle S_IDLE, o_timeout=1, no o_done_ch, pointer advances as for done.
  - i_done and expiry in the same cycle: done wins, no timeout.
- Back-to-back: o_busy drops for at least one cycle (S_IDLE) between grants. Minimum 3 cycles from one done to the next o_eng_start is not required; exactly done+1 → idle, done+2 → next o_eng_start.
- Stray done: i_done in S_IDLE is ignored; no outputs change.
- i_clr: highest priority after reset. Next cycle: S_IDLE, pending/overrun/watchdog cleared, o_busy=0, pointer kept, no done/timeout pulse. A start coincident with i_clr is dropped.
- o_grant_id holds its last value while idle.
- Watchdog arithmetic: unsigned, TIMEOUT_W bits, saturates (never wraps). TIMEOUT must be < 2^TIMEOUT_W, checked by elaboration assertion.

Decomposition:
- Package ss_pkg: state enum (S_IDLE, S_BUSY); localparam function for channel-index width ($clog2 with minimum 1).
- Sub-module ss_rr_arbiter: combinational round-robin priority select.
  - Inputs: request vector, pointer.
  - Outputs: grant valid, grant index.
  - Parameter: NUM_CH.
- Top holds pending/overrun registers, FSM, watchdog.

Test Plan:
- Single request: i_start=4'b0100 for 1 cycle at t → o_pending[2]=1 at t+1; o_eng_start=1, o_grant_id=2, o_busy=1 at t+2. i_done at t+10 → o_done_ch=4'b0100, o_busy=0 at t+11.
- Round-robin fairness: all four start together, each served with done after 5 busy cycles.
  - Grant order 0,1,2,3.
  - Re-request ch0 and ch3 while ch3 is busy → next order 0,3.
  - o_eng_start gap is 2 cycles after each done.
- Overrun: ch1 start, then ch1 start again while pending → o_overrun[1]=1 sticky; ch1 served only once. i_clr → o_overrun=0.
- Watchdog: TIMEOUT=8, start ch0, no done → o_timeout=1 exactly 8 cycles after o_eng_start; then S_IDLE, o_done_ch=0. Pending ch1 is granted 1 cycle later.
- Done/timeout collision: TIMEOUT=8, i_done in the expiry cycle → o_done_ch[0]=1, o_timeout=0. Stray i_done while idle → no output change.
- Async reset mid-busy: i_rst_n low during S_BUSY with pending 4'b1010 → all outputs 0 immediately. After release, new ch3 start → grant 3 (pointer restarted at 0, no other pending).
